// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard receiver: FSM encoding, frame geometry, parity helper.
package ps2_kbd_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned BYTE_W    = 8;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with registered head output and drop indication on push-while-full.
module ps2_sync_fifo #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WIDTH  = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic             drop_o,
  output logic [ADDR_W:0]  count_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_c, pop_ok_c, push_ok_c;

  assign count_o   = wr_q - rd_q;
  assign empty_o   = (wr_q == rd_q);
  assign full_c    = (count_o == CNT_W'(DEPTH));
  // A pop on an empty FIFO is ignored; a pop frees room for a same-cycle push when full.
  assign pop_ok_c  = pop_i & ~empty_o;
  assign push_ok_c = push_i & (~full_c | pop_ok_c);
  assign drop_o    = push_i & ~push_ok_c;
  assign head_o    = head_q;

  // Next head: the incoming byte when it lands at the new read pointer, else stored data.
  always_comb begin
    wr_d   = wr_q + CNT_W'(push_ok_c);
    rd_d   = rd_q + CNT_W'(pop_ok_c);
    head_d = head_q;
    if (push_ok_c || pop_ok_c) begin
      if (rd_d == wr_q) begin
        if (push_ok_c) head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_d[ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_q[ADDR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, frame FSM with timeout, sticky error flags,
// and a scan-code FIFO drained by an active-low read strobe.
module ps2_kbd_rx_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              rdn,
  input  logic              err_clr,
  output logic [BYTE_W-1:0] data,
  output logic              ready,
  output logic              overflow,
  output logic              parity_err,
  output logic              frame_err,
  output logic [ADDR_W:0]   count
);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BIT_W = $clog2(BYTE_W);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   ps2_clk_prev_q;
  logic                   ps2_clk_s, ps2_data_s, fall_c;
  logic [1:0]             state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      sr_q, sr_d;
  logic                   par_q, par_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   push_c, par_set_c, frm_set_c;
  logic                   ovf_q, ovf_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                   fifo_empty, fifo_drop;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall_c     = ps2_clk_prev_q & ~ps2_clk_s;

  // Frame FSM and inter-edge timeout; everything advances only on a synced ps2_clk fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_d     = par_q;
    timer_d   = timer_q;
    push_c    = 1'b0;
    par_set_c = 1'b0;
    frm_set_c = 1'b0;
    if (state_q != ST_IDLE) timer_d = timer_q + 1'b1;
    if (fall_c) begin
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!ps2_data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          sr_d      = {ps2_data_s, sr_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(BYTE_W - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = ps2_data_s;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (!odd_parity_ok(sr_q, par_q)) par_set_c = 1'b1;
          else if (!ps2_data_s)            frm_set_c = 1'b1;
          else                             push_c    = 1'b1;
        end
      endcase
    end else if ((state_q != ST_IDLE) && (timer_q == TMR_W'(TIMEOUT_CYC))) begin
      state_d   = ST_IDLE;
      timer_d   = '0;
      frm_set_c = 1'b1;
    end
  end

  // Sticky flags: a set event in the same cycle wins over err_clr.
  always_comb begin
    ovf_d     = fifo_drop ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    par_err_d = par_set_c ? 1'b1 : (err_clr ? 1'b0 : par_err_q);
    frm_err_d = frm_set_c ? 1'b1 : (err_clr ? 1'b0 : frm_err_q);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q     <= '1;
      data_sync_q    <= '1;
      ps2_clk_prev_q <= 1'b1;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      sr_q           <= '0;
      par_q          <= 1'b0;
      timer_q        <= '0;
      ovf_q          <= 1'b0;
      par_err_q      <= 1'b0;
      frm_err_q      <= 1'b0;
    end else begin
      clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q    <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      ps2_clk_prev_q <= ps2_clk_s;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      sr_q           <= sr_d;
      par_q          <= par_d;
      timer_q        <= timer_d;
      ovf_q          <= ovf_d;
      par_err_q      <= par_err_d;
      frm_err_q      <= frm_err_d;
    end
  end

  ps2_sync_fifo #(
    .ADDR_W (ADDR_W),
    .WIDTH  (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push_i  (push_c),
    .wdata_i (sr_q),
    .pop_i   (~rdn),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (count),
    .head_o  (data)
  );

  assign ready      = ~fifo_empty;
  assign overflow   = ovf_q;
  assign parity_err = par_err_q;
  assign frame_err  = frm_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Bench for ps2_kbd_rx_fifo: directed frame scenarios plus random traffic scored against a queue model.
module tb_ps2_kbd_rx_fifo;
  import ps2_kbd_pkg::*;

  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned DEPTH       = 8;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic              clk = 1'b0;
  logic              clrn, ps2_clk, ps2_data, rdn, err_clr;
  logic [7:0]        data;
  logic              ready, overflow, parity_err, frame_err;
  logic [ADDR_W:0]   count;

  byte unsigned model_q[$];
  bit           exp_ovf, exp_par, exp_frm;
  int           n_checks = 0;
  int           n_pass   = 0;

  always #10 clk = ~clk;

  ps2_kbd_rx_fifo #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rdn        (rdn),
    .err_clr    (err_clr),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .count      (count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check_val({tag, ".ready"}, 32'(ready), 32'(model_q.size() > 0));
    if (model_q.size() > 0) check_val({tag, ".data"}, 32'(data), 32'(model_q[0]));
    check_val({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check_val({tag, ".parity_err"}, 32'(parity_err), 32'(exp_par));
    check_val({tag, ".frame_err"}, 32'(frame_err), 32'(exp_frm));
  endtask

  // One PS/2 bit: data set mid-high phase, clock low 40ns, high 40ns.
  // rd_pulse holds rdn low for the single clk cycle in which this fall is acted upon.
  task automatic drive_bit(input logic v, input bit rd_pulse);
    @(negedge clk) ps2_data = v;
    @(negedge clk) ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 if (rd_pulse) rdn = 1'b0;
    @(negedge clk) ps2_clk = 1'b1;
    @(posedge clk);
    #1 rdn = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input logic stop_v,
                            input bit rd_at_push);
    logic p;
    p = ~(^b);
    if (par_bad) p = ~p;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0);
    drive_bit(p, 1'b0);
    drive_bit(stop_v, rd_at_push);
    @(negedge clk) ps2_data = 1'b1;
    if (((^b) ^ p) == 1'b0) exp_par = 1'b1;
    else if (!stop_v) exp_frm = 1'b1;
    else begin
      if (rd_at_push && model_q.size() > 0) void'(model_q.pop_front());
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int ndata);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < ndata; i++) drive_bit(b[i], 1'b0);
    @(negedge clk) ps2_data = 1'b1;
  endtask

  // Holds rdn low for n cycles; pops beyond the model's occupancy must be ignored.
  task automatic pop_burst(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (model_q.size() > 0) begin
        check_val({tag, ".pop_data"}, 32'(data), 32'(model_q[0]));
        void'(model_q.pop_front());
      end
      rdn = 1'b0;
    end
    @(negedge clk) rdn = 1'b1;
    check_state(tag);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_par = 1'b0;
    exp_frm = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b0;
    repeat (3) @(negedge clk);
    model_q.delete();
    exp_ovf = 1'b0;
    exp_par = 1'b0;
    exp_frm = 1'b0;
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int op;
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rdn = 1'b1; err_clr = 1'b0;
    do_reset();
    check_val("rst.data", 32'(data), 32'h0);
    check_state("rst");
    @(negedge clk) clrn = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rel.data", 32'(data), 32'h0);
    check_state("rel");

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_state("good_1c");
    pop_burst("pop_1c", 1);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check_state("par_bad");
    pulse_err_clr();
    check_state("par_clr");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    check_state("fill9");
    pulse_err_clr();
    check_state("ovf_clr");
    send_frame(8'h0A, 1'b0, 1'b1, 1'b1);
    check_state("full_push_pop");
    pop_burst("drain8", 8);
    pop_burst("pop_empty", 2);

    send_frame(8'h33, 1'b0, 1'b1, 1'b1);
    check_state("empty_push_pop");
    pop_burst("pop_33", 1);

    send_frame(8'h44, 1'b0, 1'b0, 1'b0);
    check_state("stop0");
    pulse_err_clr();
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    check_state("par_and_stop");
    pulse_err_clr();

    send_partial(8'hA7, 4);
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    exp_frm = 1'b1;
    check_state("timeout");
    pulse_err_clr();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_state("after_timeout");

    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_partial(8'hF0, 2);
    do_reset();
    @(negedge clk) clrn = 1'b1;
    check_state("mid_reset");
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check_state("after_reset_f0");

    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) send_frame(8'($urandom), 1'b0, 1'b1, ($urandom_range(0, 3) == 0));
      else if (op == 6) send_frame(8'($urandom), 1'b1, 1'($urandom), 1'b0);
      else if (op == 7) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
      else if (op == 8) pop_burst("rnd_pop", int'($urandom_range(1, 4)));
      else pulse_err_clr();
      check_state("rnd");
    end
    pop_burst("final_drain", DEPTH + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
